// File: rtl/cpu_debug_jtag_initiator.sv
// ----------------------------------------------------------------------------
// cpu_debug_jtag_initiator
//
// Host-side driver for the CPU debug slave's virtual-JTAG port. It stands in
// for the hard virtual-JTAG hub. A command (virtual IR value plus DR payload)
// is played out as UIR -> CDR -> SDR x DR_WIDTH -> UDR. Each state lasts one
// or more whole tck periods. The bits the slave returns on tdo are collected
// into a response word.
//
// Ports
//   clk, reset          system clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_ir, cmd_data    virtual IR to load and DR payload (shifted LSB first)
//   rsp_valid, rsp_data one-cycle response pulse; data held until next pulse
//   vji_tck, vji_tdi    generated JTAG clock and serial data to the slave
//   vji_tdo             serial data from the slave
//   vji_ir_in           virtual IR presented to the slave
//   vji_ir_out          slave IR status, latched into ir_status during UIR
//   vji_uir/cdr/sdr/udr virtual state strobes
//   vji_rti             run-test-idle indication
// ----------------------------------------------------------------------------
module cpu_debug_jtag_initiator #(
    parameter int TCK_DIV  = 2,
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic [IR_WIDTH-1:0] ir_status,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int DIV_W = $clog2(2 * TCK_DIV + 1);
    localparam int BIT_W = $clog2(DR_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(TCK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RSP
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DR_WIDTH-1:0] shift_q, shift_d;
    logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic [IR_WIDTH-1:0] ir_status_q, ir_status_d;
    logic                tck_q, tck_d;
    logic                tdi_q, tdi_d;
    logic                cmd_ready_q, cmd_ready_d;

    logic busy;        // a JTAG sequence is being clocked out
    logic tck_rise;    // this edge raises tck
    logic period_end;  // this edge lowers tck and closes the period

    always_comb begin
        busy       = (state_q == S_UIR) || (state_q == S_CDR) ||
                     (state_q == S_SDR) || (state_q == S_UDR);
        tck_rise   = busy && (div_cnt_q == DIV_RISE);
        period_end = busy && (div_cnt_q == DIV_LAST);

        state_d     = state_q;
        div_cnt_d   = '0;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rsp_data_d  = rsp_data_q;
        ir_in_d     = ir_in_q;
        ir_status_d = ir_status_q;
        tdi_d       = tdi_q;

        if (busy && !period_end) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                // cmd_ready_q is only ever high here, so it qualifies accept
                if (cmd_valid && cmd_ready_q) begin
                    state_d = S_UIR;
                    ir_in_d = cmd_ir;
                    shift_d = cmd_data;
                end
            end
            S_UIR: begin
                if (tck_rise) begin
                    ir_status_d = vji_ir_out;
                end
                if (period_end) begin
                    state_d = S_CDR;
                end
            end
            S_CDR: begin
                bit_cnt_d = '0;
                if (period_end) begin
                    state_d = S_SDR;
                end
            end
            S_SDR: begin
                // tdo is taken on the same edge that raises tck, i.e. the
                // slave's value from before its own shift on that rise
                if (tck_rise) begin
                    shift_d = {vji_tdo, shift_q[DR_WIDTH-1:1]};
                end
                if (period_end) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_UDR;
                    end
                end
            end
            S_UDR: begin
                if (period_end) begin
                    state_d    = S_RSP;
                    rsp_data_d = shift_q;
                end
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // tdi only moves at period boundaries. By then the shift register
        // has already advanced on the previous rise, so bit 0 is the next
        // bit to present.
        if (period_end) begin
            tdi_d = (state_d == S_SDR) ? shift_q[0] : 1'b0;
        end

        tck_d       = (div_cnt_d >= DIV_HIGH);
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rsp_data_q  <= '0;
            ir_in_q     <= '0;
            ir_status_q <= '0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rsp_data_q  <= rsp_data_d;
            ir_in_q     <= ir_in_d;
            ir_status_q <= ir_status_d;
            tck_q       <= tck_d;
            tdi_q       <= tdi_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // Strobes decode directly from the state register. The state register
    // only changes at period boundaries, so the strobes do too.
    assign vji_uir   = (state_q == S_UIR);
    assign vji_cdr   = (state_q == S_CDR);
    assign vji_sdr   = (state_q == S_SDR);
    assign vji_udr   = (state_q == S_UDR);
    assign vji_rti   = !busy;
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_data  = rsp_data_q;
    assign cmd_ready = cmd_ready_q;
    assign vji_tck   = tck_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_in_q;
    assign ir_status = ir_status_q;

endmodule

// File: tb/tb_cpu_debug_jtag_initiator.sv
// ----------------------------------------------------------------------------
// Bench for cpu_debug_jtag_initiator: default build (TCK_DIV=2) plus a
// TCK_DIV=1 build. Each drives a loopback slave: a 38-bit shift register,
// loaded on the cdr tck rise, tdo = sr[0], shifting tdi in on sdr tck rises.
// ----------------------------------------------------------------------------
module tb_cpu_debug_jtag_initiator;

    localparam int DR = 38;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    // ---------------- DUT 0 (TCK_DIV = 2) ----------------
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_ir    = '0;
    logic [DR-1:0] cmd_data  = '0;
    logic          rsp_valid;
    logic [DR-1:0] rsp_data;
    logic          tck, tdi, tdo;
    logic [1:0]    ir_in;
    logic [1:0]    ir_out    = '0;
    logic [1:0]    ir_status;
    logic          uir, cdr, sdr, udr, rti;

    cpu_debug_jtag_initiator #(.TCK_DIV(2), .DR_WIDTH(DR), .IR_WIDTH(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo),
        .vji_ir_in(ir_in), .vji_ir_out(ir_out), .ir_status(ir_status),
        .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr), .vji_udr(udr),
        .vji_rti(rti)
    );

    logic [DR-1:0] sr0        = '0;
    logic [DR-1:0] sr0_init   = '0;
    logic [DR-1:0] sr0_at_udr = '0;
    assign tdo = sr0[0];

    int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0;
    int t_uir = 0, t_cdr = 0, t_sdr_first = 0, t_sdr_last = 0, t_udr = 0;

    always @(posedge tck) begin
        if (cdr)      sr0 <= sr0_init;
        else if (sdr) sr0 <= {tdi, sr0[DR-1:1]};
        if (udr) sr0_at_udr <= sr0;
        if (uir) begin n_uir <= n_uir + 1; t_uir <= cyc; end
        if (cdr) begin n_cdr <= n_cdr + 1; t_cdr <= cyc; t_sdr_first <= -1; end
        if (sdr) begin
            n_sdr <= n_sdr + 1;
            t_sdr_last <= cyc;
            if (t_sdr_first < 0) t_sdr_first <= cyc;
        end
        if (udr) begin n_udr <= n_udr + 1; t_udr <= cyc; end
    end

    // tdi may only change on the edge that lowers tck
    logic tdi_prev = 1'b0;
    int   tdi_bad  = 0;
    int   n_rsp    = 0;
    always @(negedge clk) begin
        tdi_prev <= tdi;
        if (tdi !== tdi_prev && tck) tdi_bad <= tdi_bad + 1;
        if (rsp_valid) n_rsp <= n_rsp + 1;
    end

    // ---------------- DUT 1 (TCK_DIV = 1) ----------------
    logic          d1_cmd_valid = 1'b0;
    logic          d1_cmd_ready;
    logic [1:0]    d1_cmd_ir    = '0;
    logic [DR-1:0] d1_cmd_data  = '0;
    logic          d1_rsp_valid;
    logic [DR-1:0] d1_rsp_data;
    logic          d1_tck, d1_tdi, d1_tdo;
    logic [1:0]    d1_ir_in;
    logic [1:0]    d1_ir_out    = '0;
    logic [1:0]    d1_ir_status;
    logic          d1_uir, d1_cdr, d1_sdr, d1_udr, d1_rti;

    cpu_debug_jtag_initiator #(.TCK_DIV(1), .DR_WIDTH(DR), .IR_WIDTH(2)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready),
        .cmd_ir(d1_cmd_ir), .cmd_data(d1_cmd_data),
        .rsp_valid(d1_rsp_valid), .rsp_data(d1_rsp_data),
        .vji_tck(d1_tck), .vji_tdi(d1_tdi), .vji_tdo(d1_tdo),
        .vji_ir_in(d1_ir_in), .vji_ir_out(d1_ir_out), .ir_status(d1_ir_status),
        .vji_uir(d1_uir), .vji_cdr(d1_cdr), .vji_sdr(d1_sdr), .vji_udr(d1_udr),
        .vji_rti(d1_rti)
    );

    logic [DR-1:0] sr1        = '0;
    logic [DR-1:0] sr1_init   = '0;
    logic [DR-1:0] sr1_at_udr = '0;
    int            n_sdr1     = 0;
    assign d1_tdo = sr1[0];

    always @(posedge d1_tck) begin
        if (d1_cdr)      sr1 <= sr1_init;
        else if (d1_sdr) sr1 <= {d1_tdi, sr1[DR-1:1]};
        if (d1_udr) sr1_at_udr <= sr1;
        if (d1_sdr) n_sdr1 <= n_sdr1 + 1;
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [1:0]    ir;
        logic [DR-1:0] data;
        logic [DR-1:0] init;      // slave capture value
        logic [1:0]    ir_out;    // slave IR status
        logic [DR-1:0] exp_rsp;
        logic [DR-1:0] exp_sr;    // slave register at udr
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Call at a negedge. Returns the cycle count seen just before the accept edge.
    task automatic accept_cmd(input logic [1:0] ir, input logic [DR-1:0] data, output int acc_cyc);
        cmd_ir    = ir;
        cmd_data  = data;
        cmd_valid = 1'b1;
        acc_cyc   = -1;
        for (int i = 0; i < 400; i++) begin
            if (cmd_ready) begin acc_cyc = cyc; break; end
            @(negedge clk);
        end
        if (acc_cyc < 0) chk("accept_timeout", 64'(acc_cyc), 64'(0));
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rsp_cyc, output int ready_hi);
        rsp_cyc  = -1;
        ready_hi = 0;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin rsp_cyc = cyc; break; end
            if (cmd_ready) ready_hi++;
            @(negedge clk);
        end
        if (rsp_cyc < 0) chk("rsp_timeout", 64'(rsp_cyc), 64'(0));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int a, r, rh, s_uir, s_cdr, s_sdr, s_udr, s_bad;
        s_uir = n_uir; s_cdr = n_cdr; s_sdr = n_sdr; s_udr = n_udr; s_bad = tdi_bad;
        ir_out   = v.ir_out;
        sr0_init = v.init;
        accept_cmd(v.ir, v.data, a);
        wait_rsp(r, rh);
        chk({tag, "_latency"},   64'(r - a), 64'(165));
        chk({tag, "_rsp_data"},  64'(rsp_data), 64'(v.exp_rsp));
        chk({tag, "_slave_sr"},  64'(sr0_at_udr), 64'(v.exp_sr));
        chk({tag, "_ir_in"},     64'(ir_in), 64'(v.ir));
        chk({tag, "_ir_status"}, 64'(ir_status), 64'(v.ir_out));
        chk({tag, "_sdr_rises"}, 64'(n_sdr - s_sdr), 64'(38));
        chk({tag, "_uir_rises"}, 64'(n_uir - s_uir), 64'(1));
        chk({tag, "_cdr_rises"}, 64'(n_cdr - s_cdr), 64'(1));
        chk({tag, "_udr_rises"}, 64'(n_udr - s_udr), 64'(1));
        chk({tag, "_order"},
            64'((t_uir < t_cdr) && (t_cdr < t_sdr_first) &&
                (t_sdr_first < t_sdr_last) && (t_sdr_last < t_udr)), 64'(1));
        chk({tag, "_tdi_stable"}, 64'(tdi_bad - s_bad), 64'(0));
        chk({tag, "_ready_busy"}, 64'(rh), 64'(0));
        $display("transfer %s: ir=%0h data=%0h rsp=%0h latency=%0d", tag, v.ir, v.data, rsp_data, r - a);
    endtask

    initial begin
        int a, b, r, rh, n, s_udr, s_rsp;
        logic prev;

        vecs[0] = '{2'b01, 38'h3F_0000_0001, 38'h15_5555_5555, 2'b11, 38'h15_5555_5555, 38'h3F_0000_0001};
        vecs[1] = '{2'b11, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 2'b00, 38'h3F_FFFF_FFFF, 38'h00_0000_0000};
        vecs[2] = '{2'b00, 38'h2A_AAAA_AAAA, 38'h00_1234_5678, 2'b10, 38'h00_1234_5678, 38'h2A_AAAA_AAAA};
        vecs[3] = '{2'b10, 38'h20_0000_0001, 38'h1F_FFFF_FFFE, 2'b01, 38'h1F_FFFF_FFFE, 38'h20_0000_0001};

        // ---- reset, asserted between clock edges ----
        #1 reset = 1'b1;
        #2;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_rti",       64'(rti), 64'(1));
        chk("rst_tck",       64'(tck), 64'(0));
        chk("rst_strobes",   64'({uir, cdr, sdr, udr, tdi}), 64'(0));
        chk("rst_rsp",       64'({rsp_valid, rsp_data}), 64'(0));
        chk("rst_ir",        64'({ir_in, ir_status}), 64'(0));
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        chk("rst_ready_before_edge", 64'(cmd_ready), 64'(0));
        @(negedge clk);
        chk("rst_ready_after_edge", 64'(cmd_ready), 64'(1));
        chk("rst_rti_after", 64'(rti), 64'(1));
        $display("reset: cmd_ready=%0b rti=%0b", cmd_ready, rti);

        // ---- table-driven single transfers ----
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // ---- back-to-back with a held request ----
        ir_out   = vecs[0].ir_out;
        sr0_init = vecs[0].init;
        accept_cmd(vecs[0].ir, vecs[0].data, a);
        cmd_ir    = 2'b10;
        cmd_data  = 38'h01_2345_6789;
        cmd_valid = 1'b1;
        wait_rsp(r, rh);
        chk("b2b_a_latency",  64'(r - a), 64'(165));
        chk("b2b_ready_busy", 64'(rh), 64'(0));
        chk("b2b_a_ir_in",    64'(ir_in), 64'(2'b01));
        chk("b2b_a_rsp",      64'(rsp_data), 64'(38'h15_5555_5555));
        $display("transfer b2b_A: rsp=%0h", rsp_data);
        ir_out   = 2'b01;
        sr0_init = 38'h3A_BCDE_F012;
        accept_cmd(2'b10, 38'h01_2345_6789, b);
        chk("b2b_b_accept_gap", 64'(b - r), 64'(1));
        wait_rsp(r, rh);
        chk("b2b_b_latency",   64'(r - b), 64'(165));
        chk("b2b_b_rsp",       64'(rsp_data), 64'(38'h3A_BCDE_F012));
        chk("b2b_b_ir_in",     64'(ir_in), 64'(2'b10));
        chk("b2b_b_ir_status", 64'(ir_status), 64'(2'b01));
        chk("b2b_b_slave_sr",  64'(sr0_at_udr), 64'(38'h01_2345_6789));
        $display("transfer b2b_B: rsp=%0h gap=%0d", rsp_data, b - r);
        @(negedge clk);

        // ---- reset on the 20th SDR tck rise ----
        ir_out   = vecs[2].ir_out;
        sr0_init = vecs[2].init;
        accept_cmd(vecs[1].ir, vecs[1].data, a);
        n    = 0;
        prev = tck;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tck && !prev && sdr) n++;
            prev = tck;
            if (n == 20) break;
        end
        chk("abort_reached_20", 64'(n), 64'(20));
        s_udr = n_udr;
        s_rsp = n_rsp;
        #2 reset = 1'b1;
        #1;
        chk("abort_sdr",       64'(sdr), 64'(0));
        chk("abort_tck",       64'(tck), 64'(0));
        chk("abort_rsp_data",  64'(rsp_data), 64'(0));
        chk("abort_outputs",   64'({rsp_valid, udr, uir, cdr, tdi, cmd_ready}), 64'(0));
        chk("abort_rti",       64'(rti), 64'(1));
        @(negedge clk); @(negedge clk); @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 200; i++) @(negedge clk);
        chk("abort_no_udr",  64'(n_udr - s_udr), 64'(0));
        chk("abort_no_rsp",  64'(n_rsp - s_rsp), 64'(0));
        chk("abort_ready",   64'(cmd_ready), 64'(1));
        $display("abort: sdr_rises=%0d udr_after=%0d rsp_after=%0d", n, n_udr - s_udr, n_rsp - s_rsp);
        run_vec(vecs[3], "post_abort");
        @(negedge clk);

        // ---- TCK_DIV = 1 build ----
        d1_ir_out    = 2'b11;
        sr1_init     = 38'h15_5555_5555;
        d1_cmd_ir    = 2'b01;
        d1_cmd_data  = 38'h3F_0000_0001;
        d1_cmd_valid = 1'b1;
        n = n_sdr1;
        a = -1;
        for (int i = 0; i < 400; i++) begin
            if (d1_cmd_ready) begin a = cyc; break; end
            @(negedge clk);
        end
        if (a < 0) chk("d1_accept_timeout", 64'(a), 64'(0));
        @(negedge clk);
        d1_cmd_valid = 1'b0;
        r = -1;
        for (int i = 0; i < 400; i++) begin
            if (d1_rsp_valid) begin r = cyc; break; end
            @(negedge clk);
        end
        chk("d1_latency",   64'(r - a), 64'(83));
        chk("d1_rsp_data",  64'(d1_rsp_data), 64'(38'h15_5555_5555));
        chk("d1_slave_sr",  64'(sr1_at_udr), 64'(38'h3F_0000_0001));
        chk("d1_ir_in",     64'(d1_ir_in), 64'(2'b01));
        chk("d1_ir_status", 64'(d1_ir_status), 64'(2'b11));
        chk("d1_sdr_rises", 64'(n_sdr1 - n), 64'(38));
        $display("transfer d1: rsp=%0h latency=%0d", d1_rsp_data, r - a);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
